// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : Fetch program-counter generator. Next-PC priority is trap, then
//            held redirect, then fresh execute redirect, then sequential step.
//            Optional macro PC_GEN_PERF_EN adds saturating event counters.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int              STEP       = 4,
    parameter logic [XLEN-1:0] ALIGN_MASK = XLEN'(1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic            is_JAL,
    input  logic            is_JALR,
    input  logic [XLEN-1:0] opr_res,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vec,
`ifdef PC_GEN_PERF_EN
    output logic [XLEN-1:0] redir_cnt,
    output logic [XLEN-1:0] stall_cnt,
    output logic [XLEN-1:0] misalign_cnt,
`endif
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next,
    output logic            flush,
    output logic            misaligned,
    output logic            pend_valid
);

    localparam logic [XLEN-1:0] c_STEP    = XLEN'(STEP);
    localparam logic [XLEN-1:0] c_LSB_CLR = ~XLEN'(1);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_pc;
    logic            r_pend_valid;
    logic            r_misaligned;

    logic [XLEN-1:0] w_tgt;
    logic            w_ex_redir;
    logic            w_mis;
    logic            w_redir_ok;
    logic [XLEN-1:0] w_pc_next;
    logic            w_flush;
    logic            w_pend_valid_nxt;
    logic [XLEN-1:0] w_pend_pc_nxt;

    // JALR clears bit 0 only when it is the sole redirect source.
    assign w_tgt      = (br_taken || is_JAL) ? opr_res : (opr_res & c_LSB_CLR);
    assign w_ex_redir = br_taken || is_JAL || is_JALR;
    assign w_mis      = w_ex_redir && ((w_tgt & ALIGN_MASK) != '0);
    assign w_redir_ok = w_ex_redir && !w_mis;

    always_comb begin
        w_pc_next        = r_pc;
        w_flush          = 1'b0;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_pc_nxt    = r_pend_pc;
        if (trap_req) begin
            w_pc_next        = trap_vec;
            w_flush          = 1'b1;
            w_pend_valid_nxt = 1'b0;
        end else if (r_pend_valid && !stall) begin
            // Held redirect belongs to the older instruction; a fresh one is wrong-path.
            w_pc_next        = r_pend_pc;
            w_flush          = 1'b1;
            w_pend_valid_nxt = 1'b0;
        end else if (w_redir_ok && !stall) begin
            w_pc_next = w_tgt;
            w_flush   = 1'b1;
        end else if (w_redir_ok) begin
            w_pend_pc_nxt    = w_tgt;
            w_pend_valid_nxt = 1'b1;
        end else if (!stall && !w_mis) begin
            w_pc_next = r_pc + c_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_VEC;
            r_pend_pc    <= '0;
            r_pend_valid <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_pend_pc    <= w_pend_pc_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_misaligned <= w_mis;
        end
    end

    assign pc_out     = r_pc;
    assign pc_next    = w_pc_next;
    assign flush      = w_flush;
    assign misaligned = r_misaligned;
    assign pend_valid = r_pend_valid;

`ifdef PC_GEN_PERF_EN
    logic [XLEN-1:0] r_redir_cnt;
    logic [XLEN-1:0] r_stall_cnt;
    logic [XLEN-1:0] r_misalign_cnt;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redir_cnt    <= '0;
            r_stall_cnt    <= '0;
            r_misalign_cnt <= '0;
        end else begin
            if (w_flush && (r_redir_cnt != '1)) begin
                r_redir_cnt <= r_redir_cnt + XLEN'(1);
            end
            if (stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + XLEN'(1);
            end
            if (w_mis && (r_misalign_cnt != '1)) begin
                r_misalign_cnt <= r_misalign_cnt + XLEN'(1);
            end
        end
    end

    assign redir_cnt    = r_redir_cnt;
    assign stall_cnt    = r_stall_cnt;
    assign misalign_cnt = r_misalign_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Scoreboard bench for pc_gen: two instances (halfword/step 4 and
//            word/step 2) share random stimulus checked against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    typedef struct {
        logic [31:0] pc_now;
        logic        pend_now;
        logic [31:0] pc_next;
        logic        flush;
        logic [31:0] pc_after;
        logic        pend_after;
        logic        mis_after;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, br_taken = 1'b0, is_JAL = 1'b0, is_JALR = 1'b0, trap_req = 1'b0;
    logic [31:0] opr_res = '0, trap_vec = '0;

    logic [31:0] pc_out0, pc_next0, pc_out1, pc_next1;
    logic        flush0, mis0, pend0, flush1, mis1, pend1;
`ifdef PC_GEN_PERF_EN
    logic [31:0] rc0, sc0, mc0, rc1, sc1, mc1;
`endif

    int checks = 0;
    int errors = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] m_pc[2];
    logic [31:0] m_pend[2];
    bit          m_pend_v[2];

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .STEP(4), .ALIGN_MASK(32'h1)) u_dut0 (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .is_JAL(is_JAL),
        .is_JALR(is_JALR), .opr_res(opr_res), .trap_req(trap_req), .trap_vec(trap_vec),
`ifdef PC_GEN_PERF_EN
        .redir_cnt(rc0), .stall_cnt(sc0), .misalign_cnt(mc0),
`endif
        .pc_out(pc_out0), .pc_next(pc_next0), .flush(flush0), .misaligned(mis0),
        .pend_valid(pend0)
    );

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .STEP(2), .ALIGN_MASK(32'h3)) u_dut1 (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .is_JAL(is_JAL),
        .is_JALR(is_JALR), .opr_res(opr_res), .trap_req(trap_req), .trap_vec(trap_vec),
`ifdef PC_GEN_PERF_EN
        .redir_cnt(rc1), .stall_cnt(sc1), .misalign_cnt(mc1),
`endif
        .pc_out(pc_out1), .pc_next(pc_next1), .flush(flush1), .misaligned(mis1),
        .pend_valid(pend1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]     = 32'h0;
            m_pend[k]   = 32'h0;
            m_pend_v[k] = 1'b0;
        end
    endtask

    // Reference: next PC straight from the priority rules, per instance alignment/step.
    task automatic predict(input int k, output exp_t e);
        logic [31:0] tgt, mask, stp;
        bit          redir, mis;
        mask  = (k == 0) ? 32'h1 : 32'h3;
        stp   = (k == 0) ? 32'd4 : 32'd2;
        tgt   = (br_taken || is_JAL) ? opr_res : {opr_res[31:1], 1'b0};
        redir = br_taken || is_JAL || is_JALR;
        mis   = redir && ((tgt & mask) != 0);
        e.pc_now    = m_pc[k];
        e.pend_now  = m_pend_v[k];
        e.flush     = 1'b0;
        e.mis_after = mis;
        if (trap_req) begin
            e.pc_next = trap_vec; e.flush = 1'b1; m_pend_v[k] = 1'b0;
        end else if (m_pend_v[k] && !stall) begin
            e.pc_next = m_pend[k]; e.flush = 1'b1; m_pend_v[k] = 1'b0;
        end else if (redir && !mis && !stall) begin
            e.pc_next = tgt; e.flush = 1'b1;
        end else if (redir && !mis) begin
            m_pend[k] = tgt; m_pend_v[k] = 1'b1; e.pc_next = m_pc[k];
        end else if (stall || mis) begin
            e.pc_next = m_pc[k];
        end else begin
            e.pc_next = m_pc[k] + stp;
        end
        m_pc[k]      = e.pc_next;
        e.pc_after   = e.pc_next;
        e.pend_after = m_pend_v[k];
    endtask

    task automatic step(input bit s, input bit b, input bit j, input bit jr,
                        input logic [31:0] opr, input bit t, input logic [31:0] tv);
        exp_t e0, e1;
        @(negedge clk);
        stall = s; br_taken = b; is_JAL = j; is_JALR = jr;
        opr_res = opr; trap_req = t; trap_vec = tv;
        predict(0, e0);
        predict(1, e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q0.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("drain_timeout", 32'(q0.size()), 32'd0);
    endtask

    // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
    initial begin : monitor
        exp_t e0, e1;
        forever begin
            @(negedge clk);
            #2;
            if (q0.size() > 0) begin
                e0 = q0[0];
                e1 = q1[0];
                chk("pc_out0", pc_out0, e0.pc_now);
                chk("pend0", 32'(pend0), 32'(e0.pend_now));
                chk("pc_next0", pc_next0, e0.pc_next);
                chk("flush0", 32'(flush0), 32'(e0.flush));
                chk("pc_out1", pc_out1, e1.pc_now);
                chk("pend1", 32'(pend1), 32'(e1.pend_now));
                chk("pc_next1", pc_next1, e1.pc_next);
                chk("flush1", 32'(flush1), 32'(e1.flush));
                @(posedge clk);
                #1;
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                chk("pc_after0", pc_out0, e0.pc_after);
                chk("pend_after0", 32'(pend0), 32'(e0.pend_after));
                chk("mis_after0", 32'(mis0), 32'(e0.mis_after));
                chk("pc_after1", pc_out1, e1.pc_after);
                chk("pend_after1", 32'(pend1), 32'(e1.pend_after));
                chk("mis_after1", 32'(mis1), 32'(e1.mis_after));
            end
        end
    end

    initial begin : main
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc_out0, 32'h0);
        chk("rst_pend", 32'(pend0), 32'd0);
        chk("rst_mis", 32'(mis0), 32'd0);
        rst = 1'b0;

        // Free run from reset vector.
        idle(); after_edge(); chk("run_pc4", pc_out0, 32'h4);
        idle(); after_edge(); chk("run_pc8", pc_out0, 32'h8);
        idle(); after_edge(); chk("run_pc12", pc_out0, 32'hC);

        // Branch redirect.
        step(0, 1, 0, 0, 32'h100, 0, 0); after_edge(); chk("br_100", pc_out0, 32'h100);
        step(0, 1, 0, 0, 32'h200, 0, 0); #2; chk("br_flush", 32'(flush0), 32'd1);
        after_edge(); chk("br_200", pc_out0, 32'h200);
        idle(); after_edge(); chk("br_204", pc_out0, 32'h204);

        // JALR bit-0 clear, then word-alignment rejection on instance 1.
        step(0, 0, 0, 1, 32'h301, 0, 0); after_edge();
        chk("jalr_300_0", pc_out0, 32'h300);
        chk("jalr_300_1", pc_out1, 32'h300);
        step(0, 0, 0, 1, 32'h302, 0, 0); after_edge();
        chk("mis_hold1", pc_out1, 32'h300);
        chk("mis_pulse1", 32'(mis1), 32'd1);
        idle(); after_edge(); chk("mis_clear1", 32'(mis1), 32'd0);

        // Redirect during stall held until release.
        step(1, 0, 1, 0, 32'h400, 0, 0);
        step(1, 0, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 0, 32'h0, 0, 0); after_edge();
        chk("pend_set", 32'(pend0), 32'd1);
        idle(); #2; chk("pend_flush", 32'(flush0), 32'd1);
        after_edge();
        chk("pend_pc", pc_out0, 32'h400);
        chk("pend_clr", 32'(pend0), 32'd0);

        // Trap overrides stall and pending.
        step(1, 0, 1, 0, 32'h400, 0, 0);
        step(1, 0, 0, 0, 32'h0, 1, 32'h80); #2; chk("trap_flush", 32'(flush0), 32'd1);
        after_edge();
        chk("trap_pc", pc_out0, 32'h80);
        chk("trap_pend", 32'(pend0), 32'd0);

        // Silent wrap.
        step(0, 1, 0, 0, 32'hFFFF_FFFC, 0, 0);
        idle(); after_edge(); chk("wrap0", pc_out0, 32'h0);

        // Asynchronous reset while a redirect is pending.
        step(0, 1, 0, 0, 32'h1000, 0, 0);
        step(1, 0, 1, 0, 32'h2000, 0, 0);
        drain();
        chk("pre_rst_pc", pc_out0, 32'h1000);
        chk("pre_rst_pend", 32'(pend0), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_pc", pc_out0, 32'h0);
        chk("async_pend", 32'(pend0), 32'd0);
`ifdef PC_GEN_PERF_EN
        chk("perf_redir", rc0, 32'h0);
        chk("perf_stall", sc0, 32'h0);
        chk("perf_mis", mc0, 32'h0);
`endif
        model_reset();
        after_edge();
        rst = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] opr;
            opr = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFF8 : $urandom;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 opr, $urandom_range(0, 31) == 0, $urandom & 32'hFFFF_FFFC);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the pipelined core. It owns the fetch PC register and selects the next PC with fixed priority: trap vector, then branch/JAL/JALR target, then sequential step.
- Supports stall hold and latches a redirect that arrives during a stall until the stall releases.
- Flags misaligned targets and emits a flush pulse for IF/ID.

Parameters:
- XLEN, 32, width of PC and target buses.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- STEP, 4, sequential increment in bytes; legal values 2 or 4.
- ALIGN_MASK, 1, target bits that must be zero: 1 = halfword alignment, 3 = word alignment.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC this cycle
- br_taken  in  1  conditional branch resolved taken in EX
- is_JAL  in  1  JAL in EX
- is_JALR  in  1  JALR in EX
- opr_res  in  XLEN  ALU-computed target
- trap_req  in  1  trap/exception redirect request
- trap_vec  in  XLEN  trap handler address
- pc_out  out  XLEN  registered fetch PC
- pc_next  out  XLEN  combinational value pc_out will take at next edge
- flush  out  1  combinational; a redirect is committed to PC this cycle
- misaligned  out  1  registered one-cycle pulse; rejected target was misaligned
- pend_valid  out  1  registered; a redirect is held pending stall release

Behaviour:
- Reset, asynchronous on rst high: pc_out=RESET_VEC, pend_valid=0, pend_pc=0, misaligned=0. First fetch PC after release is RESET_VEC.
- Effective target:
  - tgt = opr_res when br_taken or is_JAL.
  - tgt = opr_res & ~1 when is_JALR only.
  - If is_JALR is asserted together with br_taken or is_JAL, the br/JAL form wins.
- Execute redirect: ex_redir = br_taken | is_JAL | is_JALR.
- Misalignment: ex_redir and (tgt & ALIGN_MASK) != 0.
  - The redirect is rejected; misaligned pulses high the next cycle for exactly one cycle.
  - PC holds its current value that cycle. It does not step.
  - No pending capture.
- Priority, evaluated each cycle:
  1. trap_req:
     - pc_next=trap_vec (unchecked), flush=1, pend_valid cleared.
     - Overrides stall and any pending redirect.
  2. pend_valid and !stall: pc_next=pend_pc, flush=1, pend_valid cleared.
  3. Aligned ex_redir and !stall: pc_next=tgt, flush=1.
  4. Aligned ex_redir and stall: pend_pc<=tgt, pend_valid<=1, PC holds, flush=0.
     - A later aligned redirect while pending overwrites pend_pc.
  5. stall: PC holds.
  6. Otherwise: pc_next=pc_out+STEP, modulo 2^XLEN. Wrap from all-ones region to 0 is silent.
- Pending and fresh redirect together when !stall: the pending value wins (older instruction) and the fresh redirect is dropped. Upstream flush guarantees this is a wrong-path redirect.
- Latency:
  - Redirect inputs to pc_out update: one clock edge.
  - flush and pc_next are same-cycle combinational.
- No X propagation: control inputs that are X are treated as 0 by the bench. The RTL must not latch.

Optional Feature:
- Macro: PC_GEN_PERF_EN.
- When defined, the block adds three outputs, each XLEN wide:
  - redir_cnt: applied redirects, trap included.
  - stall_cnt: cycles with stall=1.
  - misalign_cnt: rejected targets.
- Counters reset to 0 on rst and saturate at all-ones.
- When not defined, these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Reset then 3 free-run cycles, RESET_VEC=0 -> pc_out 0, 4, 8, 12; flush=0.
- pc_out=0x100, br_taken=1, opr_res=0x200 -> flush=1 same cycle; next pc_out=0x200; then 0x204.
- is_JALR=1, opr_res=0x301, ALIGN_MASK=1 -> pc_out=0x300. With ALIGN_MASK=3 and opr_res=0x302 -> PC holds, misaligned pulses 1 cycle.
- stall=1, is_JAL=1, opr_res=0x400 for 1 cycle, stall held 3 cycles -> pend_valid=1, PC frozen. On stall release: flush=1, pc_out=0x400, pend_valid=0.
- pend_valid=1 (pend_pc=0x400), stall=1, trap_req=1, trap_vec=0x80 -> pc_out=0x80 next edge, pend_valid=0, flush=1.
- rst asserted mid-pending with pc_out=0x1000 -> pc_out=RESET_VEC and pend_valid=0 immediately (asynchronous). With PC_GEN_PERF_EN: all counters read 0.
